// File: rtl/alg_ae_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alg_ae_ctrl
//  Purpose  : Auto-exposure controller. Once per frame it divides
//             target*pix_cnt by the luma sum to get the brightness ratio
//             (Q.FRAC), drives the ISP digital gain, and steps the sensor
//             exposure / analog gain with damping, hysteresis and limits.
//             Sensor register changes are handed to the I2C/SCCB writer at
//             the next frame start.
//  Revision : 1.0  initial release
// ============================================================================
module alg_ae_ctrl #(
    parameter int BITS       = 8,
    parameter int FRAC       = 4,
    parameter int DGAIN_W    = 8,
    parameter int EXPO_W     = 10,
    parameter int AGAIN_W    = 10,
    parameter int DAMP_SHIFT = 1
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                in_vsync,
    input  logic                stat_done,
    input  logic [31:0]         pix_cnt,
    input  logic [31:0]         sum,
    input  logic [BITS-1:0]     target_val,
    input  logic [FRAC+7:0]     ratio_hi,
    input  logic [FRAC+7:0]     ratio_lo,
    input  logic [EXPO_W-1:0]   expo_min,
    input  logic [EXPO_W-1:0]   expo_max,
    input  logic [AGAIN_W-1:0]  again_min,
    input  logic [AGAIN_W-1:0]  again_max,
    output logic [DGAIN_W-1:0]  dgain,
    output logic [FRAC+7:0]     ratio,
    output logic                busy,
    output logic                cmos_change_start,
    input  logic                cmos_change_done,
    output logic [EXPO_W-1:0]   cmos_exposure,
    output logic [AGAIN_W-1:0]  cmos_gain
);

    // Dividend width, ratio width, step-math width and divider counter width.
    localparam int c_nw = 32 + BITS;
    localparam int c_rw = FRAC + 8;
    localparam int c_xw = (EXPO_W > AGAIN_W) ? EXPO_W : AGAIN_W;
    localparam int c_sw = c_xw + FRAC + 8;
    localparam int c_cw = $clog2(c_nw + 1);

    localparam logic [c_cw-1:0]    c_cnt_last   = c_nw[c_cw-1:0];
    localparam logic [DGAIN_W-1:0] c_dgain_one  = DGAIN_W'(1) << FRAC;
    localparam logic [c_rw-1:0]    c_ratio_one  = c_rw'(1) << FRAC;
    localparam logic [EXPO_W-1:0]  c_expo_rst   = EXPO_W'(8'h80);
    localparam logic [AGAIN_W-1:0] c_gain_rst   = AGAIN_W'(8'h10);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_UPD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Divider datapath. num_q holds the dividend and, as its MSBs shift out,
    // collects the quotient bits at its LSB end.
    logic [c_cw-1:0]    cnt_q, cnt_d;
    logic [c_nw-1:0]    num_q, num_d;
    logic [31:0]        den_q, den_d;
    logic [31:0]        rem_q, rem_d;
    logic [BITS-1:0]    tgt_q, tgt_d;

    // Published results and sensor state. expo_q/gain_q are the working
    // (shadow) values; cmos_*_q are what the writer currently sees.
    logic [c_rw-1:0]    ratio_q, ratio_d;
    logic [DGAIN_W-1:0] dgain_q, dgain_d;
    logic [EXPO_W-1:0]  expo_q, expo_d;
    logic [AGAIN_W-1:0] gain_q, gain_d;
    logic [EXPO_W-1:0]  cmos_exposure_q, cmos_exposure_d;
    logic [AGAIN_W-1:0] cmos_gain_q, cmos_gain_d;
    logic               pending_q, pending_d;
    logic               start_q, start_d;
    logic               vsync_q, vsync_d;

    logic [32:0]        rem_sh;
    logic [32:0]        rem_diff;
    logic               rem_ge;
    logic [c_rw-1:0]    q_ratio;
    logic [DGAIN_W-1:0] q_dgain;
    logic [c_sw-1:0]    e_x, g_x, st, nv;
    logic               frame_start, frozen, launch, changed;

    // Damped step magnitude, never below 1. Guarded against a ratio on the
    // "wrong" side of unity when the thresholds are programmed oddly.
    function automatic logic [c_sw-1:0] step_size(input logic [c_sw-1:0] x,
                                                  input logic [c_rw-1:0] r,
                                                  input logic            up);
        logic [c_sw-1:0] scaled;
        logic [c_sw-1:0] raw;
        logic [c_sw-1:0] s;
        scaled = (x * {{(c_sw-c_rw){1'b0}}, r}) >> FRAC;
        if (up) raw = (scaled > x) ? scaled - x : '0;
        else    raw = (x > scaled) ? x - scaled : '0;
        s = raw >> DAMP_SHIFT;
        if (s == '0) s = {{(c_sw-1){1'b0}}, 1'b1};
        return s;
    endfunction

    function automatic logic [c_sw-1:0] step_up(input logic [c_sw-1:0] x,
                                                input logic [c_sw-1:0] s,
                                                input logic [c_sw-1:0] lim);
        logic [c_sw-1:0] t;
        t = x + s;
        return (t > lim) ? lim : t;
    endfunction

    function automatic logic [c_sw-1:0] step_dn(input logic [c_sw-1:0] x,
                                                input logic [c_sw-1:0] s,
                                                input logic [c_sw-1:0] lim);
        return (x >= lim + s) ? x - s : lim;
    endfunction

    assign e_x = {{(c_sw-EXPO_W){1'b0}}, expo_q};
    assign g_x = {{(c_sw-AGAIN_W){1'b0}}, gain_q};

    // One restoring-division step. With a zero divisor the compare always
    // succeeds, so the quotient naturally comes out all-ones.
    assign rem_sh   = {rem_q, num_q[c_nw-1]};
    assign rem_ge   = (rem_sh >= {1'b0, den_q});
    assign rem_diff = rem_sh - {1'b0, den_q};

    // Saturate the raw quotient to the ratio and dgain widths.
    assign q_ratio = (|num_q[c_nw-1:c_rw])    ? '1 : num_q[c_rw-1:0];
    assign q_dgain = (|num_q[c_nw-1:DGAIN_W]) ? '1 : num_q[DGAIN_W-1:0];

    // State register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: accept stats only when idle, so a pulse while busy is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (stat_done) state_d = S_DIV;
            S_DIV:   if (cnt_q == c_cnt_last) state_d = S_UPD;
            S_UPD:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divider: capture operands when idle, form the product in the first DIV
    // cycle (keeps the 32xBITS multiplier off the stats input path), then
    // produce one quotient bit per cycle.
    always_comb begin
        cnt_d = cnt_q;
        num_d = num_q;
        den_d = den_q;
        rem_d = rem_q;
        tgt_d = tgt_q;
        case (state_q)
            S_IDLE: begin
                if (stat_done) begin
                    num_d = {{(c_nw-32){1'b0}}, pix_cnt};
                    tgt_d = target_val;
                    den_d = sum >> FRAC;
                    rem_d = '0;
                    cnt_d = '0;
                end
            end
            S_DIV: begin
                cnt_d = cnt_q + c_cw'(1);
                if (cnt_q == '0) begin
                    num_d = {{(c_nw-32){1'b0}}, num_q[31:0]} * {{32{1'b0}}, tgt_q};
                end else begin
                    rem_d = rem_ge ? rem_diff[31:0] : rem_sh[31:0];
                    num_d = {num_q[c_nw-2:0], rem_ge};
                end
            end
            default: ;
        endcase
    end

    // Sensor step: brighten uses exposure first then gain; darken uses gain
    // first then exposure. Inside the hysteresis band nothing moves.
    always_comb begin
        expo_d = expo_q;
        gain_d = gain_q;
        st     = '0;
        nv     = '0;
        if (state_q == S_UPD && enable) begin
            if (q_ratio > ratio_hi) begin
                if (expo_q == expo_max) begin
                    st     = step_size(g_x, q_ratio, 1'b1);
                    nv     = step_up(g_x, st, {{(c_sw-AGAIN_W){1'b0}}, again_max});
                    gain_d = nv[AGAIN_W-1:0];
                end else begin
                    st     = step_size(e_x, q_ratio, 1'b1);
                    nv     = step_up(e_x, st, {{(c_sw-EXPO_W){1'b0}}, expo_max});
                    expo_d = nv[EXPO_W-1:0];
                end
            end else if (q_ratio < ratio_lo) begin
                if (gain_q == again_min) begin
                    st     = step_size(e_x, q_ratio, 1'b0);
                    nv     = step_dn(e_x, st, {{(c_sw-EXPO_W){1'b0}}, expo_min});
                    expo_d = nv[EXPO_W-1:0];
                end else begin
                    st     = step_size(g_x, q_ratio, 1'b0);
                    nv     = step_dn(g_x, st, {{(c_sw-AGAIN_W){1'b0}}, again_min});
                    gain_d = nv[AGAIN_W-1:0];
                end
            end
        end
    end

    // Results, writer handshake and the frozen-output window.
    always_comb begin
        vsync_d     = in_vsync;
        frame_start = vsync_q & ~in_vsync;
        frozen      = start_q | ~cmos_change_done;
        launch      = ~start_q & frame_start & pending_q & cmos_change_done;
        changed     = (expo_d != expo_q) | (gain_d != gain_q);

        ratio_d = ratio_q;
        if (state_q == S_UPD) ratio_d = q_ratio;

        dgain_d = dgain_q;
        if (!enable)               dgain_d = c_dgain_one;
        else if (state_q == S_UPD) dgain_d = q_dgain;

        // While the writer is busy the visible registers hold; the working
        // values catch up as soon as it reports idle again.
        cmos_exposure_d = frozen ? cmos_exposure_q : expo_d;
        cmos_gain_d     = frozen ? cmos_gain_q     : gain_d;

        start_d = start_q;
        if (start_q && !cmos_change_done) start_d = 1'b0;
        else if (launch)                  start_d = 1'b1;

        // A change landing in the launch cycle is visible immediately, so the
        // launch already covers it.
        pending_d = pending_q;
        if (launch)       pending_d = 1'b0;
        else if (changed) pending_d = 1'b1;
    end

    // Datapath and handshake registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= '0;
            num_q           <= '0;
            den_q           <= '0;
            rem_q           <= '0;
            tgt_q           <= '0;
            ratio_q         <= c_ratio_one;
            dgain_q         <= c_dgain_one;
            expo_q          <= c_expo_rst;
            gain_q          <= c_gain_rst;
            cmos_exposure_q <= c_expo_rst;
            cmos_gain_q     <= c_gain_rst;
            pending_q       <= 1'b0;
            start_q         <= 1'b0;
            vsync_q         <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            num_q           <= num_d;
            den_q           <= den_d;
            rem_q           <= rem_d;
            tgt_q           <= tgt_d;
            ratio_q         <= ratio_d;
            dgain_q         <= dgain_d;
            expo_q          <= expo_d;
            gain_q          <= gain_d;
            cmos_exposure_q <= cmos_exposure_d;
            cmos_gain_q     <= cmos_gain_d;
            pending_q       <= pending_d;
            start_q         <= start_d;
            vsync_q         <= vsync_d;
        end
    end

    assign ratio             = ratio_q;
    assign dgain             = dgain_q;
    assign busy              = (state_q != S_IDLE);
    assign cmos_change_start = start_q;
    assign cmos_exposure     = cmos_exposure_q;
    assign cmos_gain         = cmos_gain_q;

endmodule
`default_nettype wire
